// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch redirect controller.
//   fetch_state_t : controller states
//   redirect_t    : one redirect request (valid / trap flag / target)
//   pend_merge    : decides whether a new redirect replaces a buffered one
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD_RST = 2'd0,
    RUN      = 2'd1,
    STALL    = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic        is_trap;
    logic [31:0] target;
  } redirect_t;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0400;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0380;

  localparam redirect_t REDIRECT_NONE = '{valid: 1'b0, is_trap: 1'b0, target: 32'h0};

  // A buffered redirect is only displaced by a trap beating a non-trap;
  // an empty buffer takes whatever arrives.
  function automatic redirect_t pend_merge(input redirect_t pend, input redirect_t req);
    redirect_t res;
    res = pend;
    if (req.valid) begin
      if (!pend.valid)
        res = req;
      else if (req.is_trap && !pend.is_trap)
        res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_prio.sv
// Combinational priority select of redirect sources: trap > branch > jump.
// Optional macro FETCH_REDIRECT_MISALIGN_TRAP_EN: misaligned branch/jump
// targets become trap redirects and raise misalign. Without it, target
// bits [1:0] are cleared.
// Ports:
//   trap_valid                   trap request (target TRAP_VECTOR)
//   branch_taken, branch_target  taken-branch request
//   jump_valid, jump_target      jump request
//   redirect                     winning request
//   misalign                     (macro only) a misaligned target was converted
module redirect_prio
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
  input  logic        trap_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output redirect_t   redirect
`ifdef FETCH_REDIRECT_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  logic [31:0] br_tgt;
  logic [31:0] jp_tgt;
  logic        br_mis;
  logic        jp_mis;
  logic        trap_any;

`ifdef FETCH_REDIRECT_MISALIGN_TRAP_EN
  assign br_mis   = branch_taken & (branch_target[1:0] != 2'b00);
  assign jp_mis   = jump_valid & (jump_target[1:0] != 2'b00);
  assign br_tgt   = branch_target;
  assign jp_tgt   = jump_target;
  assign misalign = br_mis | jp_mis;
`else
  assign br_mis   = 1'b0;
  assign jp_mis   = 1'b0;
  assign br_tgt   = branch_target & ~32'h3;
  assign jp_tgt   = jump_target & ~32'h3;
`endif

  assign trap_any = trap_valid | br_mis | jp_mis;

  always_comb begin
    redirect = REDIRECT_NONE;
    if (trap_any) begin
      redirect.valid   = 1'b1;
      redirect.is_trap = 1'b1;
      redirect.target  = TRAP_VECTOR;
    end else if (branch_taken) begin
      redirect.valid  = 1'b1;
      redirect.target = br_tgt;
    end else if (jump_valid) begin
      redirect.valid  = 1'b1;
      redirect.target = jp_tgt;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// PC sequencing control: each cycle the PC increments, holds, or loads a
// redirect target. A redirect seen while fetch is stalled is buffered and
// applied, with a flush, on the cycle the stall releases.
// Optional macro FETCH_REDIRECT_MISALIGN_TRAP_EN adds misalign_fault.
// Ports:
//   clk, rst            clock, async active-low reset
//   pcAddress           current fetch address from the PC
//   stall_req           hazard hold request
//   imem_ready          instruction memory accepted the fetch
//   trap_valid          trap redirect (TRAP_VECTOR)
//   branch_taken/target taken-branch redirect
//   jump_valid/target   jump redirect
//   shouldUseNewPC      PC loads newPC instead of incrementing
//   newPC               address to load
//   flush               invalidate fetch/decode instruction
//   fetch_valid         pcAddress is a valid, non-held fetch
//   misalign_fault      (macro only) misaligned target converted to trap
//
// state    | meaning
// HOLD_RST | post-reset window, PC forced to RESET_PC, redirects ignored
// RUN      | normal fetch, redirects applied in the same cycle
// STALL    | PC held at last_pc, redirects buffered until release
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC          = RESET_PC_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR       = TRAP_VECTOR_DEFAULT,
  parameter int unsigned RESET_HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcAddress,
  input  logic        stall_req,
  input  logic        imem_ready,
  input  logic        trap_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic        shouldUseNewPC,
  output logic [31:0] newPC,
  output logic        flush,
  output logic        fetch_valid
`ifdef FETCH_REDIRECT_MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

  fetch_state_t state, state_nxt;
  logic [3:0]   hold_cnt, hold_nxt;
  logic [31:0]  last_pc;
  redirect_t    pend, pend_nxt, pend_m;
  redirect_t    req;
  logic         stall;

  assign stall = stall_req | ~imem_ready;

  redirect_prio #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_prio (
    .trap_valid   (trap_valid),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_valid   (jump_valid),
    .jump_target  (jump_target),
    .redirect     (req)
`ifdef FETCH_REDIRECT_MISALIGN_TRAP_EN
    ,
    .misalign     (prio_misalign)
`endif
  );

`ifdef FETCH_REDIRECT_MISALIGN_TRAP_EN
  logic prio_misalign;
  // Requests are dropped in HOLD_RST, so no conversion happens there.
  assign misalign_fault = prio_misalign & (state != HOLD_RST);
`endif

  // Buffered redirect including anything arriving this cycle.
  assign pend_m = pend_merge(pend, req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HOLD_RST;
      hold_cnt <= '0;
      last_pc  <= RESET_PC;
      pend     <= REDIRECT_NONE;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      last_pc  <= pcAddress;
      pend     <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold_cnt;
    pend_nxt       = pend;
    shouldUseNewPC = 1'b0;
    newPC          = pcAddress;
    flush          = 1'b0;
    fetch_valid    = 1'b0;

    unique case (state)
      RUN: begin
        if (!stall) begin
          fetch_valid = 1'b1;
          if (req.valid) begin
            shouldUseNewPC = 1'b1;
            newPC          = req.target;
            flush          = 1'b1;
          end
        end else begin
          shouldUseNewPC = 1'b1;
          newPC          = pcAddress;
          state_nxt      = STALL;
          if (req.valid)
            pend_nxt = req;
        end
      end

      STALL: begin
        shouldUseNewPC = 1'b1;
        newPC          = last_pc;
        if (!stall) begin
          fetch_valid = 1'b1;
          state_nxt   = RUN;
          pend_nxt    = REDIRECT_NONE;
          // Covers a buffered redirect, a trap displacing it, and a
          // same-cycle redirect into an empty buffer.
          if (pend_m.valid) begin
            newPC = pend_m.target;
            flush = 1'b1;
          end
        end else begin
          pend_nxt = pend_m;
        end
      end

      default: begin
        // HOLD_RST, and recovery from the unused encoding.
        shouldUseNewPC = 1'b1;
        newPC          = RESET_PC;
        if (state != HOLD_RST) begin
          state_nxt = HOLD_RST;
          hold_nxt  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with a behavioural PC register
// closing the loop (reset 0x3FC, loads newPC or adds 4 each clock).
module tb_fetch_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        stall_req;
  logic        imem_ready;
  logic        trap_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        use_pc;
  logic [31:0] new_pc;
  logic        flush;
  logic        fetch_valid;
`ifdef FETCH_REDIRECT_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        use_e;
    logic [31:0] npc_e;
    logic        flush_e;
    logic        fv_e;
    logic [31:0] pc_e;
  } exp_t;

  exp_t exp_q[$];

  fetch_redirect_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pcAddress     (pc),
    .stall_req     (stall_req),
    .imem_ready    (imem_ready),
    .trap_valid    (trap_valid),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .shouldUseNewPC(use_pc),
    .newPC         (new_pc),
    .flush         (flush),
    .fetch_valid   (fetch_valid)
`ifdef FETCH_REDIRECT_MISALIGN_TRAP_EN
    ,
    .misalign_fault(misalign_fault)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'h0000_03FC;
    else      pc <= use_pc ? new_pc : pc + 32'd4;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  task automatic drv(input logic sr, input logic rdy, input logic tv, input logic bt,
                     input logic [31:0] btgt, input logic jv, input logic [31:0] jtgt);
    stall_req     = sr;
    imem_ready    = rdy;
    trap_valid    = tv;
    branch_taken  = bt;
    branch_target = btgt;
    jump_valid    = jv;
    jump_target   = jtgt;
  endtask

  task automatic idle();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (exp_q.size() != 0)
    else begin
      failures++;
      $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (pc === e.pc_e)
      else begin
        failures++;
        $error("FAIL %s pcAddress: observed=%h expected=%h", e.tag, pc, e.pc_e);
      end
      checks++;
      assert (use_pc === e.use_e)
      else begin
        failures++;
        $error("FAIL %s shouldUseNewPC: observed=%b expected=%b", e.tag, use_pc, e.use_e);
      end
      if (e.use_e) begin
        checks++;
        assert (new_pc === e.npc_e)
        else begin
          failures++;
          $error("FAIL %s newPC: observed=%h expected=%h", e.tag, new_pc, e.npc_e);
        end
      end
      checks++;
      assert (flush === e.flush_e)
      else begin
        failures++;
        $error("FAIL %s flush: observed=%b expected=%b", e.tag, flush, e.flush_e);
      end
      checks++;
      assert (fetch_valid === e.fv_e)
      else begin
        failures++;
        $error("FAIL %s fetch_valid: observed=%b expected=%b", e.tag, fetch_valid, e.fv_e);
      end
    end
  endtask

  // Inputs are already applied (at a falling edge); queue the expectation,
  // let the combinational outputs settle, compare, then move to the next
  // falling edge so the rising edge in between advances the design.
  task automatic cyc(input string tag, input logic use_e, input logic [31:0] npc_e,
                     input logic flush_e, input logic fv_e, input logic [31:0] pc_e);
    exp_t e;
    e.tag = tag; e.use_e = use_e; e.npc_e = npc_e;
    e.flush_e = flush_e; e.fv_e = fv_e; e.pc_e = pc_e;
    exp_q.push_back(e);
    #1;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600);
    @(negedge clk);

    // Reset overrides all requests.
    cyc("rst_a", 1'b1, 32'h400, 1'b0, 1'b0, 32'h3FC);
    cyc("rst_b", 1'b1, 32'h400, 1'b0, 1'b0, 32'h3FC);

    // Post-reset hold; a branch during hold is ignored.
    rst = 1'b1;
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    cyc("hold0", 1'b1, 32'h400, 1'b0, 1'b0, 32'h3FC);
    idle();
    cyc("hold1", 1'b1, 32'h400, 1'b0, 1'b0, 32'h400);
    cyc("run0",  1'b0, 32'h0,   1'b0, 1'b1, 32'h400);
    cyc("run1",  1'b0, 32'h0,   1'b0, 1'b1, 32'h404);
    cyc("run2",  1'b0, 32'h0,   1'b0, 1'b1, 32'h408);
    cyc("run3",  1'b0, 32'h0,   1'b0, 1'b1, 32'h40C);

    // Branch redirect, zero-cycle latency.
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    cyc("br",    1'b1, 32'h500, 1'b1, 1'b1, 32'h410);
    idle();
    cyc("br_t0", 1'b0, 32'h0,   1'b0, 1'b1, 32'h500);
    cyc("br_t1", 1'b0, 32'h0,   1'b0, 1'b1, 32'h504);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h420);
    cyc("jmp",   1'b1, 32'h420, 1'b1, 1'b1, 32'h508);

    // Hazard stall for three cycles, then re-present the held address.
    drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("stl0",    1'b1, 32'h420, 1'b0, 1'b0, 32'h420);
    cyc("stl1",    1'b1, 32'h420, 1'b0, 1'b0, 32'h420);
    cyc("stl2",    1'b1, 32'h420, 1'b0, 1'b0, 32'h420);
    idle();
    cyc("stl_rel", 1'b1, 32'h420, 1'b0, 1'b1, 32'h420);
    cyc("stl_rep", 1'b0, 32'h0,   1'b0, 1'b1, 32'h420);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h430);
    cyc("jmp2",    1'b1, 32'h430, 1'b1, 1'b1, 32'h424);

    // Jump arriving with an imem wait is buffered and applied on release.
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600);
    cyc("im_wait0", 1'b1, 32'h430, 1'b0, 1'b0, 32'h430);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("im_wait1", 1'b1, 32'h430, 1'b0, 1'b0, 32'h430);
    idle();
    cyc("im_rel",   1'b1, 32'h600, 1'b1, 1'b1, 32'h430);
    cyc("im_t0",    1'b0, 32'h0,   1'b0, 1'b1, 32'h600);

    // Pending branch displaced by a trap; a later jump does not displace it.
    drv(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
    cyc("pend_br",   1'b1, 32'h604, 1'b0, 1'b0, 32'h604);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("pend_trap", 1'b1, 32'h604, 1'b0, 1'b0, 32'h604);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800);
    cyc("pend_keep", 1'b1, 32'h604, 1'b0, 1'b0, 32'h604);
    idle();
    cyc("pend_rel",  1'b1, 32'h380, 1'b1, 1'b1, 32'h604);

    // Priority in RUN: trap > branch > jump.
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h900, 1'b1, 32'hA00);
    cyc("prio_all", 1'b1, 32'h380, 1'b1, 1'b1, 32'h380);
    idle();
    cyc("prio_t0",  1'b0, 32'h0,   1'b0, 1'b1, 32'h380);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h900, 1'b1, 32'hA00);
    cyc("prio_bj",  1'b1, 32'h900, 1'b1, 1'b1, 32'h384);

    // Low target bits are cleared.
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA03);
    cyc("mask",   1'b1, 32'hA00, 1'b1, 1'b1, 32'h900);
    idle();
    cyc("mask_t", 1'b0, 32'h0,   1'b0, 1'b1, 32'hA00);

    // Release cycle with empty buffer applies a same-cycle branch.
    drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("stl_b",    1'b1, 32'hA04, 1'b0, 1'b0, 32'hA04);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 32'hB00, 1'b0, 32'h0);
    cyc("rel_br",   1'b1, 32'hB00, 1'b1, 1'b1, 32'hA04);
    idle();
    cyc("rel_br_t", 1'b0, 32'h0,   1'b0, 1'b1, 32'hB00);

    // Reset mid-stall with a pending branch: buffer must be discarded.
    drv(1'b0, 1'b0, 1'b0, 1'b1, 32'hC00, 1'b0, 32'h0);
    cyc("rst_pend0", 1'b1, 32'hB04, 1'b0, 1'b0, 32'hB04);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rst_pend1", 1'b1, 32'hB04, 1'b0, 1'b0, 32'hB04);
    rst = 1'b0;
    cyc("rst_mid",   1'b1, 32'h400, 1'b0, 1'b0, 32'h3FC);
    rst = 1'b1;
    idle();
    cyc("rst2_h0",   1'b1, 32'h400, 1'b0, 1'b0, 32'h3FC);
    cyc("rst2_h1",   1'b1, 32'h400, 1'b0, 1'b0, 32'h400);
    cyc("rst2_r0",   1'b0, 32'h0,   1'b0, 1'b1, 32'h400);
    cyc("rst2_r1",   1'b0, 32'h0,   1'b0, 1'b1, 32'h404);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
